// File: rtl/rotr_iter.sv
// -----------------------------------------------------------------------------
// rotr_iter
//   Multi-cycle rotate-right unit for the execute stage. An operand and a
//   rotate amount are captured on an accepted start. The operand is then
//   rotated right by 2 bits per cycle, or by 1 bit for the final odd step.
//   The result register holds its value until the next start is accepted.
//
// Handshake: i_start is a request that is sampled only when the unit is not
//   busy (state IDLE or DONE). An accepted start captures i_in and i_cnt on
//   that clock edge. o_done is a one-cycle pulse that marks o_out as holding a
//   new result. o_busy and o_done are decoded from state, so they are never
//   high together. A start accepted during the DONE cycle runs back-to-back.
//
// Ports
//   i_clk    in   1      system clock, rising edge
//   i_rst    in   1      synchronous, active-high reset
//   i_start  in   1      request, sampled only when not busy
//   i_in     in   WIDTH  operand, captured on acceptance
//   i_cnt    in   CNTW   rotate-right amount, captured on acceptance
//   o_busy   out  1      high while a rotate is in progress
//   o_done   out  1      one-cycle pulse, o_out holds a new result
//   o_out    out  WIDTH  result register
//   o_state  out  2      FSM state for debug (0 IDLE, 1 BUSY, 2 DONE)
// -----------------------------------------------------------------------------
module rotr_iter #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_in,
  input  logic [CNTW-1:0]  i_cnt,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out,
  output logic [1:0]       o_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next;
  logic [WIDTH-1:0] r_out;
  logic [CNTW-1:0]  r_rem;
  logic             w_accept;
  logic             w_last_step;

  // Starts are only heard while idle or in the done cycle.
  assign w_accept    = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // In BUSY the remaining count is never zero, so 1 or 2 means this edge
  // finishes the rotation.
  assign w_last_step = (r_rem <= CNTW'(2));

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = (i_cnt == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last_step) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_accept) begin
          w_next = (i_cnt == '0) ? S_DONE : S_BUSY;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture and the 2-bit / 1-bit rotate steps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out <= '0;
      r_rem <= '0;
    end else if (w_accept) begin
      r_out <= i_in;
      r_rem <= i_cnt;
    end else if (r_state == S_BUSY) begin
      if (r_rem >= CNTW'(2)) begin
        r_out <= {r_out[1:0], r_out[WIDTH-1:2]};
        r_rem <= r_rem - CNTW'(2);
      end else if (r_rem == CNTW'(1)) begin
        r_out <= {r_out[0], r_out[WIDTH-1:1]};
        r_rem <= '0;
      end
    end
  end

  // Outputs decoded from state or taken straight from registers.
  always_comb begin
    o_busy  = (r_state == S_BUSY);
    o_done  = (r_state == S_DONE);
    o_out   = r_out;
    o_state = r_state;
  end

endmodule

// File: tb/tb_rotr_iter.sv
// -----------------------------------------------------------------------------
// tb_rotr_iter
//   Self-checking bench for rotr_iter. Each accepted operation pushes its
//   expected result to exp_q; the value is popped and compared when the DUT
//   raises done. Busy duration, done latency and the done pulse are checked
//   for every operation, plus reset, ignored-start and back-to-back cases.
// -----------------------------------------------------------------------------
module tb_rotr_iter;

  localparam int WIDTH = 16;
  localparam int CNTW  = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] in_val;
  logic [CNTW-1:0]  cnt_val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out_val;
  logic [1:0]       state;

  logic [WIDTH-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  rotr_iter #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_in    (in_val),
    .i_cnt   (cnt_val),
    .o_busy  (busy),
    .o_done  (done),
    .o_out   (out_val),
    .o_state (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rotate-right, independent of the step-wise DUT algorithm.
  function automatic logic [WIDTH-1:0] rotr_model(input logic [WIDTH-1:0] x, input int n);
    logic [2*WIDTH-1:0] d;
    d = {x, x} >> n;
    return d[WIDTH-1:0];
  endfunction

  // ---------------- driver ----------------
  // Drives one request at the current time point (caller is at a negedge),
  // then follows it to done. If interfere is set, a start with a different
  // operand is pulsed during the first busy cycle; it must be ignored.
  // Returns positioned at the negedge inside the done cycle.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [CNTW-1:0] n,
                        input bit interfere);
    int  busy_cycles;
    int  done_at;
    bit  overlap;
    bit  got;
    logic [WIDTH-1:0] exp_v;
    start   = 1'b1;
    in_val  = a;
    cnt_val = n;
    exp_q.push_back(rotr_model(a, int'(n)));
    @(posedge clk);
    #1;
    start   = 1'b0;
    in_val  = $urandom_range(0, 16'hFFFF);
    cnt_val = $urandom_range(0, 15);
    busy_cycles = 0;
    done_at = -1;
    overlap = 1'b0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (busy) busy_cycles++;
      if (interfere && k == 1) begin
        start = 1'b1; in_val = 16'hFFFF; cnt_val = 4'd3;
      end else if (interfere && k == 2) begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        done_at = k;
      end
    end
    start = 1'b0;
    check("done_seen", {31'd0, got}, 32'd1);
    check("busy_done_overlap", {31'd0, overlap}, 32'd0);
    if (got) begin
      exp_v = exp_q.pop_front();
      check($sformatf("out in=%h cnt=%0d", a, n), {16'd0, out_val}, {16'd0, exp_v});
      check($sformatf("busy_cycles cnt=%0d", n), busy_cycles, (int'(n) + 1) / 2);
      check($sformatf("done_latency cnt=%0d", n), done_at, (int'(n) + 1) / 2 + 1);
    end else begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // Called in the done cycle when no new start follows: done must drop and
  // the result must stay put.
  task automatic check_idle_after(input logic [WIDTH-1:0] held);
    @(negedge clk);
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("out_held", {16'd0, out_val}, {16'd0, held});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] ra;
    logic [CNTW-1:0]  rn;
    rst = 1'b1; start = 1'b0; in_val = '0; cnt_val = '0;
    repeat (3) @(negedge clk);
    check("reset_out", {16'd0, out_val}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases with spec-given results as literal expectations.
    run_op(16'h8001, 4'd1, 1'b0);
    check("t1_literal", {16'd0, out_val}, 32'h0000C000);
    check_idle_after(16'hC000);
    run_op(16'h1234, 4'd4, 1'b0);
    check("t2_literal", {16'd0, out_val}, 32'h00004123);
    check_idle_after(16'h4123);
    run_op(16'h0001, 4'd15, 1'b0);
    check("t3_literal", {16'd0, out_val}, 32'h00000002);
    check_idle_after(16'h0002);
    run_op(16'hABCD, 4'd0, 1'b0);
    check("t4_literal", {16'd0, out_val}, 32'h0000ABCD);
    check_idle_after(16'hABCD);

    // Start while busy must be ignored.
    run_op(16'h1234, 4'd6, 1'b1);
    check("t5_literal", {16'd0, out_val}, 32'h0000D048);
    check_idle_after(16'hD048);

    // Back-to-back: second start issued in the done cycle of the first.
    run_op(16'h00F1, 4'd3, 1'b0);
    run_op(16'h5A5A, 4'd5, 1'b0);
    run_op(16'h9999, 4'd0, 1'b0);
    run_op(16'h8000, 4'd2, 1'b0);
    check_idle_after(16'h2000);

    // Reset in the middle of an operation discards it.
    start = 1'b1; in_val = 16'hBEEF; cnt_val = 4'd8;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_out", {16'd0, out_val}, 32'd0);
    @(negedge clk);
    check("rst_mid_stays_idle", {30'd0, state}, 32'd0);
    run_op(16'h0F00, 4'd8, 1'b0);
    check("t6_literal", {16'd0, out_val}, 32'h0000000F);
    check_idle_after(16'h000F);

    // Random operations, sometimes back-to-back.
    for (int i = 0; i < 20; i++) begin
      ra = $urandom_range(0, 16'hFFFF);
      rn = $urandom_range(0, 15);
      run_op(ra, rn, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 0) check_idle_after(rotr_model(ra, int'(rn)));
    end

    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
